uart_tx_ctrl: RTL and testbench

Memory-mapped UART transmitter peripheral sitting between the SoC data bus and the `uart_tx` pin of `soc_top`. It accepts bytes from CPU stores, buffers them in a small FIFO, and serialises them as 8N1 frames at a programmable baud divisor. The default divisor gives 115200 baud from the 100 MHz system clock, which is 868 clocks per bit.

---
 rtl/uart_tx_ctrl_if.sv | 20 ++
 rtl/uart_tx_ctrl.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_ctrl_if.sv
// Bus bundle between the SoC data bus master and the UART TX peripheral.
interface uart_tx_ctrl_if;
  logic        sel;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    output sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  sel, mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/uart_tx_ctrl.sv
// Memory-mapped 8N1 UART transmitter with programmable divisor.
// Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise a single holding register is used.
module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_ctrl_if.slave  bus,
  output logic           uart_tx,
  output logic           tx_busy
);
  localparam logic [15:0] DIV_MIN = 16'd16;
  localparam logic [15:0] DIV_RST = 16'(CLKS_PER_BIT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
  state_t state, state_nxt;

  logic [15:0] div_reg, cur_div, bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift, shift_nxt, fifo_head;
  logic        fifo_full, fifo_empty, push, pop, tx_nxt, bit_end;
  logic        req, data_wr, accept;
  logic [31:0] rdata_nxt;
  logic [15:0] div_wr;
  logic        unused_bits;

  function automatic logic [15:0] clamp_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

  assign unused_bits = ^{bus.mem_wdata[31:16], bus.mem_addr[1:0]};

  // A DATA push with the FIFO full is not accepted until space appears.
  assign req     = bus.sel & bus.mem_valid;
  assign data_wr = (bus.mem_addr[3:2] == 2'd0) & bus.mem_wstrb[0];
  assign accept  = req & ~bus.mem_ready & ~(data_wr & fifo_full);
  assign push    = accept & data_wr;
  assign tx_busy = (state != S_IDLE) | ~fifo_empty;

  assign div_wr = {bus.mem_wstrb[1] ? bus.mem_wdata[15:8] : div_reg[15:8],
                   bus.mem_wstrb[0] ? bus.mem_wdata[7:0]  : div_reg[7:0]};

  always_comb begin
    rdata_nxt = '0;
    if (bus.mem_wstrb == 4'd0) begin
      case (bus.mem_addr[3:2])
        2'd1:    rdata_nxt = {29'd0, fifo_empty, fifo_full, tx_busy};
        2'd2:    rdata_nxt = {16'd0, div_reg};
        default: rdata_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_ready <= 1'b0;
      bus.mem_rdata <= '0;
      div_reg       <= DIV_RST;
    end else begin
      bus.mem_ready <= accept;
      bus.mem_rdata <= accept ? rdata_nxt : '0;
      if (accept && (bus.mem_addr[3:2] == 2'd2) && (|bus.mem_wstrb[1:0]))
        div_reg <= clamp_div(div_wr);
    end
  end

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.mem_wdata[7:0];
  end
`else
  localparam int unused_fifo_depth = FIFO_DEPTH;
  logic       hold_full;
  logic [7:0] hold;

  assign fifo_full  = hold_full;
  assign fifo_empty = ~hold_full;
  assign fifo_head  = hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    hold_full <= 1'b0;
    else if (push) hold_full <= 1'b1;
    else if (pop)  hold_full <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push) hold <= bus.mem_wdata[7:0];
  end
`endif

  assign bit_end = (state != S_IDLE) && (bit_cnt == cur_div - 16'd1);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE:  if (!fifo_empty) begin pop = 1'b1; state_nxt = S_START; end
      S_START: if (bit_end) state_nxt = S_DATA;
      S_DATA:  if (bit_end && bit_idx == 3'd7) state_nxt = S_STOP;
      S_STOP:  if (bit_end) begin
                 if (!fifo_empty) begin pop = 1'b1; state_nxt = S_START; end
                 else state_nxt = S_IDLE;
               end
      default: state_nxt = S_IDLE;
    endcase
    shift_nxt = shift;
    if (pop) shift_nxt = fifo_head;
    else if (state == S_DATA && bit_end) shift_nxt = {1'b0, shift[7:1]};
    // The line level is registered from the next state so it lines up with the state flop.
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START: tx_nxt = 1'b0;
      S_DATA:  tx_nxt = shift_nxt[0];
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      uart_tx <= 1'b1;
      bit_cnt <= '0;
      bit_idx <= '0;
      cur_div <= DIV_RST;
    end else begin
      state   <= state_nxt;
      uart_tx <= tx_nxt;
      if (pop || bit_end)      bit_cnt <= '0;
      else if (state != S_IDLE) bit_cnt <= bit_cnt + 16'd1;
      if (pop)                          bit_idx <= '0;
      else if (state == S_DATA && bit_end) bit_idx <= bit_idx + 3'd1;
      if (pop) cur_div <= div_reg;
    end
  end

  always_ff @(posedge clk) begin
    shift <= shift_nxt;
  end
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: bus handshake, frame timing, divisor rules, stall and reset.
module tb_uart_tx_ctrl;
  logic clk, rst_n, uart_tx, tx_busy;
  int   cyc;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mon_div  = 868;

  logic [7:0] rx_byte  [$];
  int         rx_start [$];
  logic       rx_frm   [$];

`ifdef UART_TX_FIFO_EN
  localparam bit FIFO_BUILD = 1'b1;
`else
  localparam bit FIFO_BUILD = 1'b0;
`endif

  uart_tx_ctrl_if bus ();

  uart_tx_ctrl #(.CLKS_PER_BIT(868), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .uart_tx(uart_tx), .tx_busy(tx_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Serial monitor: finds the start edge, samples every bit at its centre.
  initial begin : uart_mon
    int st, d;
    logic [7:0] b;
    logic st_bit, stp;
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      if (uart_tx === 1'b0 && rst_n === 1'b1) begin
        st = cyc;
        d  = mon_div;
        repeat (d / 2) @(posedge clk);
        #1 st_bit = uart_tx;
        for (int k = 0; k < 8; k++) begin
          repeat (d) @(posedge clk);
          #1 b[k] = uart_tx;
        end
        repeat (d) @(posedge clk);
        #1 stp = uart_tx;
        rx_byte.push_back(b);
        rx_start.push_back(st);
        rx_frm.push_back(st_bit === 1'b0 && stp === 1'b1);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    int g = 0;
    while (cyc < t && g < 100000) begin
      @(posedge clk); #1;
      g++;
    end
  endtask

  task automatic bus_xfer(input logic [3:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, output logic [31:0] rdata);
    int waits = 0;
    bus.sel = 1'b1; bus.mem_valid = 1'b1;
    bus.mem_addr = addr; bus.mem_wdata = wdata; bus.mem_wstrb = strb;
    do begin
      @(posedge clk); #1;
      waits++;
    end while (bus.mem_ready !== 1'b1 && waits < 20000);
    check("bus_ready", {31'd0, bus.mem_ready}, 32'd1);
    rdata = bus.mem_rdata;
    bus.sel = 1'b0; bus.mem_valid = 1'b0; bus.mem_wstrb = 4'd0;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] dummy;
    bus_xfer(addr, data, strb, dummy);
  endtask

  task automatic rd(input logic [3:0] addr, output logic [31:0] data);
    bus_xfer(addr, 32'd0, 4'd0, data);
  endtask

  task automatic wait_rx(input int n, input int budget);
    int g = 0;
    while (rx_byte.size() < n && g < budget) begin
      @(posedge clk); #1;
      g++;
    end
    check("rx_count", rx_byte.size(), n);
  endtask

  task automatic clear_rx();
    rx_byte.delete(); rx_start.delete(); rx_frm.delete();
  endtask

  initial begin : stim
    logic [31:0] v;
    int r, s, s1, s0, r3;
    logic [7:0] hi [3];
    hi[0] = 8'h48; hi[1] = 8'h69; hi[2] = 8'h0A;
    bus.sel = 1'b0; bus.mem_valid = 1'b0; bus.mem_addr = '0;
    bus.mem_wdata = '0; bus.mem_wstrb = '0;
    rst_n = 1'b0;
    tick(3);
    check("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_tx_busy", {31'd0, tx_busy}, 32'd0);
    check("rst_ready", {31'd0, bus.mem_ready}, 32'd0);
    check("rst_rdata", bus.mem_rdata, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Register reads after reset, single-cycle read latency and one-cycle ready pulse.
    bus.sel = 1'b1; bus.mem_valid = 1'b1; bus.mem_addr = 4'h4; bus.mem_wstrb = 4'd0;
    tick(1);
    check("rd_latency", {31'd0, bus.mem_ready}, 32'd1);
    check("status_rst", bus.mem_rdata, 32'h4);
    bus.sel = 1'b0; bus.mem_valid = 1'b0;
    tick(1);
    check("ready_pulse", {31'd0, bus.mem_ready}, 32'd0);
    rd(4'h8, v); check("div_rst", v, 32'd868);
    rd(4'h0, v); check("data_rd0", v, 32'd0);
    wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    rd(4'hC, v); check("rsvd_rd0", v, 32'd0);
    wr(4'h8, 32'd5, 4'h3);
    rd(4'h8, v); check("div_clamp", v, 32'd16);
    wr(4'h8, 32'd868, 4'h3);

    // First frame at 868 clocks/bit; DIV changed to 100 mid-frame applies to the next frame.
    mon_div = 868;
    wr(4'h0, 32'h41, 4'h1);
    r = cyc;
    check("lat_pre", {31'd0, uart_tx}, 32'd1);
    check("busy_rise", {31'd0, tx_busy}, 32'd1);
    tick(1);
    check("lat_start", {31'd0, uart_tx}, 32'd0);
    s1 = r + 1;
    wr(4'h8, 32'd100, 4'h3);
    wr(4'h0, 32'h5A, 4'h1);
    rd(4'h4, v); check("status_q1", v, FIFO_BUILD ? 32'h1 : 32'h3);
    rd(4'h8, v); check("div_100", v, 32'd100);
    wait_rx(1, 10000);
    mon_div = 100;
    wait_rx(2, 2000);
    check("f1_byte", rx_byte[0], 32'h41);
    check("f1_start", rx_start[0], s1);
    check("f1_frame", {31'd0, rx_frm[0]}, 32'd1);
    check("f2_byte", rx_byte[1], 32'h5A);
    check("f2_start", rx_start[1], s1 + 8680);
    check("f2_frame", {31'd0, rx_frm[1]}, 32'd1);
    wait_until(s1 + 9679);
    check("busy_hold", {31'd0, tx_busy}, 32'd1);
    check("stop_high", {31'd0, uart_tx}, 32'd1);
    tick(1);
    check("busy_fall", {31'd0, tx_busy}, 32'd0);
    rd(4'h4, v); check("status_idle", v, 32'h4);

    // "Hi\n" back-to-back at 16 clocks/bit.
    wr(4'h8, 32'd16, 4'h3);
    mon_div = 16;
    clear_rx();
    wr(4'h0, 32'(hi[0]), 4'h1);
    r = cyc; s = r + 1;
    wr(4'h0, 32'(hi[1]), 4'h1);
    wr(4'h0, 32'(hi[2]), 4'h1);
    r3 = cyc;
    check("hi_3rd_ready", r3, FIFO_BUILD ? r + 4 : r + 162);
    wait_rx(3, 2000);
    for (int i = 0; i < 3; i++) begin
      check("hi_byte", rx_byte[i], 32'(hi[i]));
      check("hi_start", rx_start[i], s + 160 * i);
      check("hi_frame", {31'd0, rx_frm[i]}, 32'd1);
    end
    wait_until(s + 482);
    check("hi_idle", {31'd0, tx_busy}, 32'd0);

`ifdef UART_TX_FIFO_EN
    // Fill the FIFO: first byte goes straight to the shifter, eight queue, the tenth stalls.
    clear_rx();
    wr(4'h0, 32'h30, 4'h1);
    s0 = cyc + 1;
    for (int i = 1; i < 9; i++) wr(4'h0, 32'h30 + 32'(i), 4'h1);
    rd(4'h4, v); check("status_full", v, 32'h3);
    wr(4'h0, 32'h39, 4'h1);
    check("stall_ready", cyc, s0 + 161);
    wait_rx(10, 3000);
    for (int i = 0; i < 10; i++) begin
      check("fifo_byte", rx_byte[i], 32'h30 + 32'(i));
      check("fifo_start", rx_start[i], s0 + 160 * i);
    end
    wait_until(s0 + 1602);
    check("fifo_idle", {31'd0, tx_busy}, 32'd0);
`endif

    // Reset in the middle of DATA bit 3 (a 0 bit of 0xA5) with another byte queued.
    wr(4'h0, 32'hA5, 4'h1);
    s = cyc + 1;
    wr(4'h0, 32'h3C, 4'h1);
    wait_until(s + 64 + 8);
    check("pre_rst_bit3", {31'd0, uart_tx}, 32'd0);
    #2 rst_n = 1'b0;
    #2;
    check("rst_async_tx", {31'd0, uart_tx}, 32'd1);
    check("rst_async_busy", {31'd0, tx_busy}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(200);
    clear_rx();
    rd(4'h4, v); check("status_post_rst", v, 32'h4);
    rd(4'h8, v); check("div_post_rst", v, 32'd868);
    tick(300);
    check("no_frames", rx_byte.size(), 32'd0);
    check("line_idle", {31'd0, uart_tx}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
